// File: rtl/neuron_l1.sv
`default_nettype none
// neuron_l1 -- layer-1 integrate-and-fire neuron: snapshot, serial sum, threshold compare, refractory.
// Rev 1.0
module neuron_l1 #(
  parameter int p_inputs       = 4,
  parameter int p_width        = 9,
  parameter int p_weight_width = 9,
  parameter int p_refractory   = 16,
  localparam int CW = p_width + p_weight_width,
  localparam int AW = CW + ((p_inputs > 1) ? $clog2(p_inputs) : 1)
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic                   i_event,
  input  logic [p_inputs*CW-1:0] i_cell_out,
  input  logic [AW-1:0]          i_threshold,
  output logic                   o_spike,
  output logic [AW-1:0]          o_potential,
  output logic                   o_busy,
  output logic                   o_drop
);

  localparam int IW = (p_inputs > 1) ? $clog2(p_inputs) : 1;
  localparam int RW = (p_refractory > 0) ? $clog2(p_refractory + 1) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    CMP  = 2'd2,
    REFR = 2'd3
  } state_t;

  state_t          state;
  logic [CW-1:0]   snap [p_inputs];
  logic [AW-1:0]   thr;
  logic [AW-1:0]   acc;
  logic [IW-1:0]   idx;
  logic [RW-1:0]   cnt;

  assign o_busy = (state != IDLE);

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state       <= IDLE;
      for (int j = 0; j < p_inputs; j++) snap[j] <= '0;
      thr         <= '0;
      acc         <= '0;
      idx         <= '0;
      cnt         <= '0;
      o_spike     <= 1'b0;
      o_potential <= '0;
      o_drop      <= 1'b0;
    end else begin
      o_spike <= 1'b0;
      o_drop  <= 1'b0;
      case (state)
        IDLE: begin
          if (i_event) begin
            for (int j = 0; j < p_inputs; j++) snap[j] <= i_cell_out[j*CW +: CW];
            thr   <= i_threshold;
            acc   <= '0;
            idx   <= '0;
            state <= ACC;
          end
        end
        ACC: begin
          o_drop <= i_event;
          // Sum is built only from the snapshot, so live input changes cannot leak in.
          acc    <= acc + AW'(snap[idx]);
          if (idx == IW'(p_inputs - 1)) begin
            state <= CMP;
          end else begin
            idx <= idx + IW'(1);
          end
        end
        CMP: begin
          o_drop      <= i_event;
          o_potential <= acc;
          o_spike     <= (acc >= thr);
          if ((acc >= thr) && (p_refractory > 0)) begin
            cnt   <= RW'(p_refractory);
            state <= REFR;
          end else begin
            state <= IDLE;
          end
        end
        REFR: begin
          o_drop <= i_event;
          cnt    <= cnt - RW'(1);
          if (cnt == RW'(1)) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_neuron_l1.sv
`default_nettype none
// tb_neuron_l1 -- directed stimulus with a queue-based scoreboard checked per evaluation window.
module tb_neuron_l1;

  localparam int CW = 18;
  localparam int AW = 20;
  localparam int N  = 4;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            ev  = 1'b0;
  logic            ev0 = 1'b0;
  logic [N*CW-1:0] cells = '0;
  logic [AW-1:0]   threshold = '0;

  logic            spike, busy, drop;
  logic [AW-1:0]   pot;
  logic            spike0, busy0, drop0;
  logic [AW-1:0]   pot0;

  always #5 clk = ~clk;

  neuron_l1 #(.p_inputs(N), .p_width(9), .p_weight_width(9), .p_refractory(16)) dut (
    .i_clk(clk), .i_rst(rst), .i_event(ev), .i_cell_out(cells), .i_threshold(threshold),
    .o_spike(spike), .o_potential(pot), .o_busy(busy), .o_drop(drop)
  );

  neuron_l1 #(.p_inputs(N), .p_width(9), .p_weight_width(9), .p_refractory(0)) dut0 (
    .i_clk(clk), .i_rst(rst), .i_event(ev0), .i_cell_out(cells), .i_threshold(threshold),
    .o_spike(spike0), .o_potential(pot0), .o_busy(busy0), .o_drop(drop0)
  );

  typedef struct {
    logic [AW-1:0] pot;
    int            spikes;
    int            len;
    int            drops;
  } exp_t;

  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic set_cells(input int a, input int b, input int c, input int d);
    cells = {CW'(d), CW'(c), CW'(b), CW'(a)};
  endtask

  task automatic push(input int p, input int s, input int l, input int d);
    exp_t e;
    e.pot = AW'(p); e.spikes = s; e.len = l; e.drops = d;
    sb.push_back(e);
  endtask

  task automatic send(input int thr);
    threshold = AW'(thr);
    ev = 1'b1;
    tick;
    ev = 1'b0;
  endtask

  // Monitor: a window opens when busy rises and closes on the first idle cycle.
  logic prev_busy = 1'b0;
  bit   in_win = 0;
  int   pos, len, nsp, ndrop, sp_pos;

  always @(negedge clk) begin
    exp_t e;
    if (!prev_busy && busy) begin
      in_win = 1; pos = 0; len = 0; nsp = 0; ndrop = 0; sp_pos = 0;
    end
    if (in_win) begin
      pos++;
      if (busy) len++;
      if (spike) begin
        nsp++;
        if (sp_pos == 0) sp_pos = pos;
      end
      if (drop) ndrop++;
      if (!busy) begin
        in_win = 0;
        if (sb.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_eval: got evaluation with potential %0d, expected none", pot);
        end else begin
          e = sb.pop_front();
          chk("potential", pot, e.pot);
          chk("spike_count", nsp, e.spikes);
          chk("busy_len", len, e.len);
          chk("drop_count", ndrop, e.drops);
          if (e.spikes > 0) chk("spike_pos", sp_pos, 6);
        end
      end
    end
    prev_busy = busy;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (2) tick;
    chk("rst_spike", spike, 0);
    chk("rst_drop", drop, 0);
    chk("rst_busy", busy, 0);
    chk("rst_potential", pot, 0);
    rst = 1'b0;
    repeat (2) tick;

    // Threshold met exactly: spike plus full refractory
    set_cells(10, 20, 30, 40);
    push(100, 1, 21, 0);
    send(100);
    repeat (25) tick;

    // One above the sum: no spike, then an event on the first idle edge is accepted
    push(100, 0, 5, 0);
    send(101);
    repeat (5) tick;
    set_cells(1, 2, 3, 4);
    push(10, 1, 21, 0);
    send(0);
    repeat (25) tick;

    // Full-scale cells must not overflow
    set_cells(18'h3FFFF, 18'h3FFFF, 18'h3FFFF, 18'h3FFFF);
    push(1048572, 1, 21, 0);
    send(0);
    repeat (25) tick;

    // Input changes after capture are ignored; events while busy are dropped
    set_cells(10, 20, 30, 40);
    push(100, 1, 21, 2);
    send(100);
    tick;
    set_cells(0, 0, 0, 0);
    threshold = '1;
    tick;
    ev = 1'b1;
    tick;
    ev = 1'b0;
    repeat (6) tick;
    ev = 1'b1;
    tick;
    ev = 1'b0;
    repeat (20) tick;

    // Asynchronous reset mid-accumulation
    set_cells(10, 20, 30, 40);
    push(0, 0, 3, 0);
    send(100);
    repeat (3) tick;
    rst = 1'b1;
    #1;
    chk("midrst_busy", busy, 0);
    chk("midrst_spike", spike, 0);
    chk("midrst_potential", pot, 0);
    repeat (2) tick;
    rst = 1'b0;
    set_cells(5, 6, 7, 8);
    push(26, 0, 5, 0);
    send(27);
    repeat (10) tick;

    // Zero refractory: back to IDLE after CMP, next-edge event accepted
    set_cells(10, 20, 30, 40);
    threshold = AW'(100);
    ev0 = 1'b1;
    tick;
    ev0 = 1'b0;
    repeat (4) tick;
    chk("r0_busy_cmp", busy0, 1);
    tick;
    chk("r0_busy_idle", busy0, 0);
    chk("r0_spike", spike0, 1);
    chk("r0_potential", pot0, 100);
    set_cells(1, 1, 1, 1);
    threshold = AW'(4);
    ev0 = 1'b1;
    tick;
    ev0 = 1'b0;
    chk("r0_drop", drop0, 0);
    chk("r0_busy_accept", busy0, 1);
    chk("r0_spike_once", spike0, 0);
    repeat (5) tick;
    chk("r0_spike2", spike0, 1);
    chk("r0_potential2", pot0, 4);

    for (int i = 0; i < 200 && sb.size() != 0; i++) tick;
    if (sb.size() != 0) begin
      checks++; errors++;
      $display("FAIL pending_evals: got %0d outstanding, expected 0", sb.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
